// File: rtl/pipa_pulse_source.sv
// pipa_pulse_source: bench-side model of the three PIPA accelerometer loops.
// Watches the AGC 3200 pps slot sync (d3200A) and, once per slot, advances a
// per-axis fractional accumulator by |rate|. A carry out of the accumulator
// emits one PULSE_W-cycle pulse on the axis' P (rate > 0) or M (rate < 0) line.
//
// Optional feature macro: PIPA_FAIL_INJECT_EN
//   defined   : fail_axis[i] sampled on a processed slot forces both P and M
//               of axis i high for that slot's pulse (illegal PIPA-fail state).
//   undefined : fail_axis is ignored and P/M stay mutually exclusive.

// ---------------------------------------------------------------------------
// One PIPA axis: rate register, fractional accumulator and pulse shaper.
// ---------------------------------------------------------------------------
module pipa_pulse_axis #(
    parameter int RATE_W  = 8,
    parameter int PULSE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_slot,     // slot edge already qualified by enable
    input  logic              i_wr,
    input  logic [RATE_W-1:0] i_wr_data,
    input  logic              i_fail,
    output logic              o_p,
    output logic              o_m
);
    localparam int ACC_W = RATE_W - 1;
    localparam int CNT_W = (PULSE_W < 2) ? 1 : $clog2(PULSE_W);
    localparam logic [ACC_W-1:0] MAG_MAX  = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

    logic [RATE_W-1:0] r_rate;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_wcnt;
    logic              r_p;
    logic              r_m;

    logic              w_neg;
    logic              w_zero;
    logic              w_min;
    logic [ACC_W-1:0]  w_mag;
    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic              w_new_p;
    logic              w_new_m;

    // Slot result: saturated magnitude, accumulate, and decide the pulse value.
    // The most negative rate has no positive twin in RATE_W-1 bits, so it is
    // clamped to the largest magnitude (e.g. -128 acts as -127).
    always_comb begin
        w_neg   = r_rate[RATE_W-1];
        w_zero  = (r_rate == '0);
        w_min   = w_neg && (r_rate[RATE_W-2:0] == '0);
        if (w_min)
            w_mag = MAG_MAX;
        else if (w_neg)
            w_mag = ~r_rate[ACC_W-1:0] + 1'b1;
        else
            w_mag = r_rate[ACC_W-1:0];
        w_sum   = {1'b0, r_acc} + {1'b0, w_mag};
        w_carry = w_sum[ACC_W];
        w_new_p = w_carry & ~w_neg & ~w_zero;
        w_new_m = w_carry & w_neg;
`ifdef PIPA_FAIL_INJECT_EN
        if (i_fail) begin
            w_new_p = 1'b1;
            w_new_m = 1'b1;
        end
`endif
    end

`ifndef PIPA_FAIL_INJECT_EN
    // Fail request has no effect in this build; keep it as a named sink only.
    logic w_unused_fail;
    assign w_unused_fail = i_fail;
`endif

    // Rate register: a write in a slot cycle lands after that slot has used the old rate.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_rate <= '0;
        else if (i_wr)
            r_rate <= i_wr_data;
    end

    // Fractional accumulator: advances once per processed slot, never cleared by writes.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_slot)
            r_acc <= w_sum[ACC_W-1:0];
    end

    // Pulse shaper: a slot (re)loads the width counter and replaces the output
    // value; otherwise the counter runs down and the outputs drop at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p    <= 1'b0;
            r_m    <= 1'b0;
            r_wcnt <= '0;
        end else if (i_slot) begin
            r_p    <= w_new_p;
            r_m    <= w_new_m;
            r_wcnt <= CNT_LOAD;
        end else if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 1'b1;
        end else begin
            r_p    <= 1'b0;
            r_m    <= 1'b0;
        end
    end

    assign o_p = r_p;
    assign o_m = r_m;
endmodule

// ---------------------------------------------------------------------------
// Top: slot sync, slot counter, write decode and the three axis instances.
// ---------------------------------------------------------------------------
module pipa_pulse_source #(
    parameter int RATE_W  = 8,
    parameter int PULSE_W = 4
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              d3200A,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [1:0]        wr_axis,
    input  logic [RATE_W-1:0] wr_data,
    input  logic [2:0]        fail_axis,
    output logic              PIPXP,
    output logic              PIPXM,
    output logic              PIPYP,
    output logic              PIPYM,
    output logic              PIPGZp,
    output logic              PIPGZm,
    output logic [15:0]       slot_cnt
);
    localparam int NUM_AXES = 3;

    logic                r_sync_q;
    logic                r_sync_qq;
    logic [15:0]         r_slot_cnt;

    logic                w_slot_edge;
    logic                w_slot;
    logic [NUM_AXES-1:0] w_wr;
    logic [NUM_AXES-1:0] w_p;
    logic [NUM_AXES-1:0] w_m;

    // Two-flop sync of the slot strobe; the edge detect runs off the synced copy.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_sync_q  <= 1'b0;
            r_sync_qq <= 1'b0;
        end else begin
            r_sync_q  <= d3200A;
            r_sync_qq <= r_sync_q;
        end
    end

    assign w_slot_edge = r_sync_q & ~r_sync_qq;
    assign w_slot      = w_slot_edge & enable;

    // Processed-slot counter, free-running wrap at 16 bits.
    always_ff @(posedge CLOCK) begin
        if (rst)
            r_slot_cnt <= '0;
        else if (w_slot)
            r_slot_cnt <= r_slot_cnt + 16'd1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            assign w_wr[gi] = wr_en && (wr_axis == 2'(gi));

            pipa_pulse_axis #(
                .RATE_W  (RATE_W),
                .PULSE_W (PULSE_W)
            ) u_axis (
                .i_clk     (CLOCK),
                .i_rst     (rst),
                .i_slot    (w_slot),
                .i_wr      (w_wr[gi]),
                .i_wr_data (wr_data),
                .i_fail    (fail_axis[gi]),
                .o_p       (w_p[gi]),
                .o_m       (w_m[gi])
            );
        end
    endgenerate

    assign PIPXP    = w_p[0];
    assign PIPXM    = w_m[0];
    assign PIPYP    = w_p[1];
    assign PIPYM    = w_m[1];
    assign PIPGZp   = w_p[2];
    assign PIPGZm   = w_m[2];
    assign slot_cnt = r_slot_cnt;
endmodule

// File: tb/tb_pipa_pulse_source.sv
// Directed bench for pipa_pulse_source (RATE_W=8, PULSE_W=4).
module tb_pipa_pulse_source;
    logic        CLOCK = 1'b0;
    logic        rst = 1'b1;
    logic        d3200A = 1'b0;
    logic        enable = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_axis = 2'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [2:0]  fail_axis = 3'd0;
    logic        PIPXP, PIPXM, PIPYP, PIPYM, PIPGZp, PIPGZm;
    logic [15:0] slot_cnt;

    pipa_pulse_source #(.RATE_W(8), .PULSE_W(4)) dut (
        .CLOCK(CLOCK), .rst(rst), .d3200A(d3200A), .enable(enable),
        .wr_en(wr_en), .wr_axis(wr_axis), .wr_data(wr_data), .fail_axis(fail_axis),
        .PIPXP(PIPXP), .PIPXM(PIPXM), .PIPYP(PIPYP), .PIPYM(PIPYM),
        .PIPGZp(PIPGZp), .PIPGZm(PIPGZm), .slot_cnt(slot_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    // bit order: 0 XP, 1 XM, 2 YP, 3 YM, 4 ZP, 5 ZM
    logic [5:0] w_outs;
    assign w_outs = {PIPGZm, PIPGZp, PIPYM, PIPYP, PIPXM, PIPXP};

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    // pulse monitor: rising edges per output, runs whose width is not 4
    logic [5:0] prev_outs = 6'd0;
    int rises [6];
    int run   [6];
    int bad_w = 0;
    bit chk_w = 1'b1;
    always @(negedge CLOCK) begin
        for (int i = 0; i < 6; i++) begin
            if (w_outs[i] === 1'b1 && prev_outs[i] !== 1'b1) rises[i]++;
            if (w_outs[i] === 1'b1) run[i]++;
            else begin
                if (run[i] != 0 && run[i] != 4 && chk_w) bad_w++;
                run[i] = 0;
            end
        end
        prev_outs = w_outs;
    end

    logic [5:0] tr [10];

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    function automatic int pat(input int b);
        int p = 0;
        for (int k = 0; k < 10; k++)
            if (tr[k][b] === 1'b1) p |= (1 << k);
        return p;
    endfunction

    task automatic clr_mon();
        for (int i = 0; i < 6; i++) begin
            rises[i] = 0;
            run[i]   = 0;
        end
        bad_w = 0;
    endtask

    task automatic wr(input logic [1:0] ax, input logic [7:0] d);
        @(negedge CLOCK);
        wr_en = 1'b1; wr_axis = ax; wr_data = d;
        @(negedge CLOCK);
        wr_en = 1'b0;
    endtask

    // One slot: d3200A high 5 cycles then low 5; tr[k-1] holds outputs at the
    // k-th falling edge after d3200A rises. Optional hooks at sample index k.
    task automatic do_slot(input int wr_k = -1, input logic [1:0] wa = 2'd0,
                           input logic [7:0] wd = 8'd0, input int en_off_k = -1,
                           input int rst_on_k = -1, input int rst_off_k = -1);
        if (enable && rst_on_k < 0) exp_cnt++;
        @(negedge CLOCK);
        d3200A = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLOCK);
            tr[k-1] = w_outs;
            if (k == 5) d3200A = 1'b0;
            if (k == wr_k) begin wr_en = 1'b1; wr_axis = wa; wr_data = wd; end
            if (k == wr_k + 1) wr_en = 1'b0;
            if (k == en_off_k) enable = 1'b0;
            if (k == rst_on_k) rst = 1'b1;
            if (k == rst_off_k) rst = 1'b0;
        end
    endtask

    initial begin
        int mask;
        int p2;
        int frozen_cnt;

        for (int i = 0; i < 6; i++) begin rises[i] = 0; run[i] = 0; end
        repeat (3) @(negedge CLOCK);
        chk("reset_outs", int'(w_outs), 0);
        chk("reset_slot_cnt", int'(slot_cnt), 0);
        rst = 1'b0;

        // A: X = +64, pulses on slots 2,4,6,8
        wr(2'd0, 8'd64);
        clr_mon();
        mask = 0; p2 = 0;
        for (int s = 1; s <= 8; s++) begin
            do_slot();
            if (pat(0) != 0) mask |= (1 << (s - 1));
            if (s == 2) p2 = pat(0);
        end
        chk("A_xp_slot_mask", mask, 32'hAA);
        chk("A_xp_slot2_timing", p2, 32'h1E);
        chk("A_xp_rises", rises[0], 4);
        chk("A_xm_rises", rises[1], 0);
        chk("A_width", bad_w, 0);
        chk("A_slot_cnt", int'(slot_cnt), 8);

        // B: Y = -32, M pulses on slots 4 and 8; then Y = 0 stops it
        wr(2'd1, 8'hE0);
        clr_mon();
        mask = 0;
        for (int s = 1; s <= 8; s++) begin
            do_slot();
            if (pat(3) != 0) mask |= (1 << (s - 1));
        end
        chk("B_ym_slot_mask", mask, 32'h88);
        chk("B_yp_rises", rises[2], 0);
        wr(2'd1, 8'd0);
        clr_mon();
        repeat (3) do_slot();
        chk("B_zero_ym_rises", rises[3], 0);
        chk("B_zero_yp_rises", rises[2], 0);
        wr(2'd0, 8'd0);   // X acc now holds 19*64 mod 128 = 64

        // C: Z = -128 saturates to -127: 127 M pulses in 128 slots, same as -127
        wr(2'd2, 8'h80);
        clr_mon();
        repeat (128) do_slot();
        chk("C_zm_rises_m128", rises[5], 127);
        chk("C_zp_rises_m128", rises[4], 0);
        wr(2'd2, 8'h81);
        clr_mon();
        repeat (128) do_slot();
        chk("C_zm_rises_m127", rises[5], 127);
        chk("C_width", bad_w, 0);
        wr(2'd2, 8'd0);
        chk("C_slot_cnt", int'(slot_cnt), exp_cnt);

        // D: write +127 to X in the slot cycle; old rate 0 applies to that slot
        do_slot(1, 2'd0, 8'h7F);
        chk("D_write_slot_xp", pat(0), 0);
        do_slot();
        chk("D_next_slot_xp", pat(0), 32'h1E);

        // E: drop enable mid-pulse, 5 frozen slots, then resume
        do_slot(-1, 2'd0, 8'd0, 3);
        chk("E_inflight_xp", pat(0), 32'h1E);
        frozen_cnt = int'(slot_cnt);
        clr_mon();
        repeat (5) do_slot();
        chk("E_frozen_rises", rises[0] + rises[1], 0);
        chk("E_frozen_slot_cnt", int'(slot_cnt), frozen_cnt);
        enable = 1'b1;
        do_slot();
        chk("E_resume_xp", pat(0), 32'h1E);
        chk("E_slot_cnt", int'(slot_cnt), exp_cnt);

        // F: reset two cycles into an X pulse
        chk_w = 1'b0;
        do_slot(-1, 2'd0, 8'd0, -1, 3, 7);
        chk("F_xp_cut", pat(0), 32'h06);
        chk("F_outs_after_rst", int'(tr[3]), 0);
        chk("F_slot_cnt_rst", int'(slot_cnt), 0);
        exp_cnt = 0;
        clr_mon();
        chk_w = 1'b1;
        wr(2'd3, 8'h7F);   // axis 3 is not a real axis
        repeat (3) do_slot();
        chk("F_no_pulses", rises[0] + rises[1] + rises[2] + rises[3] + rises[4] + rises[5], 0);
        chk("F_slot_cnt", int'(slot_cnt), 3);

        // G: fail request on Y for one slot
        fail_axis = 3'b010;
        do_slot();
        fail_axis = 3'b000;
`ifdef PIPA_FAIL_INJECT_EN
        chk("G_yp_fail", pat(2), 32'h1E);
        chk("G_ym_fail", pat(3), 32'h1E);
`else
        chk("G_yp_fail", pat(2), 0);
        chk("G_ym_fail", pat(3), 0);
`endif
        chk("G_x_quiet", pat(0) | pat(1), 0);
        chk("G_slot_cnt", int'(slot_cnt), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
